pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter stage directly upstream of the instruction memory. It holds the 24-bit byte address of the current 3-byte instruction and drives PCAddress into instruction memory. Each cycle it computes the next PC: sequential (+3), PC-relative branch, absolute jump, stall, halt or fault. A small run/halt/fault state machine gates PC updates.

Parameters:
RESET_VECTOR, 24'd0, PC value loaded on reset.
IMEM_BYTES, 128, instruction memory size in bytes; the highest legal PC is IMEM_BYTES-3.
RAS_DEPTH, 4, return-address stack entries (used only with PC_RAS_EN).

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Stall  input  1  hold the PC this cycle.
Branch  input  1  resolved taken branch.
BranchOffset  input  12  signed offset, counted in instructions.
Jump  input  1  absolute jump.
JumpTarget  input  24  byte address for Jump.
Call  input  1  subroutine call to JumpTarget.
Ret  input  1  return from subroutine.
Halt  input  1  the current instruction is HALT.
Resume  input  1  leave the HALTED state.
PCAddress  output  24  current PC, fed to instruction memory.
PCPlus3  output  24  PCAddress+3, combinational, for link/writeback.
Halted  output  1  state is HALTED.
AddrFault  output  1  state is FAULT (sticky).
RasEmpty  output  1  return-address stack is empty.

Behaviour:
- Reset (asynchronous): PCAddress=RESET_VECTOR, state=RUN, Halted=0, AddrFault=0, RAS cleared, RasEmpty=1. Reset mid-operation aborts everything immediately.
- PCAddress is a register. A redirect decided in cycle N appears on PCAddress after the edge that ends cycle N (1-cycle latency). There are no delay slots.
- Arithmetic is modulo 2^24.
  - seq = PC+3.
  - br = PC+3 + sext(BranchOffset)*3. The multiply is (off<<1)+off, sign-extended to 24 bits.
- Next-PC priority when state=RUN:
  1. Stall: hold.
  2. Halt: hold, go to HALTED.
  3. Ret (PC_RAS_EN only): pop.
  4. Call or Jump: JumpTarget.
  5. Branch: br.
  6. Otherwise: seq.
- Range check on the chosen next PC, excluding holds: if next > IMEM_BYTES-3, PC holds, state goes to FAULT, and AddrFault=1 from the next cycle.
- HALTED:
  - PC holds. Branch, Jump, Call, Ret and Halt are ignored.
  - Resume=1 with Stall=0 advances PC to seq and returns to RUN.
  - If seq is out of range, go to FAULT instead.
  - Stall=1 with Resume=1: stay HALTED.
- FAULT: sticky. PC holds and all inputs are ignored until Reset.
- Simultaneous events are resolved strictly by the priority list above. Example: Branch and Jump in the same cycle takes JumpTarget.
- Halted and AddrFault are registered decodes of the state; they are never asserted together.

Optional Feature:
Macro PC_RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular return-address stack.
  - Call pushes PC+3 and jumps to JumpTarget.
  - Ret pops and the popped value becomes the next PC, still subject to the range check.
  - Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - Ret when empty forces FAULT, PC holds.
  - Call and Ret together: Ret wins and there is no push.
  - RasEmpty reflects count==0.
  - A stalled, halted or faulted cycle neither pushes nor pops.
- Undefined:
  - No stack storage.
  - Call behaves exactly as Jump.
  - Ret is ignored and the cycle follows the remaining priority list.
  - RasEmpty tied to 1.

Test Plan:
1. Reset, then 5 idle cycles -> PCAddress 0,3,6,9,12,15; PCPlus3 tracks +3; Halted=0, AddrFault=0.
2. At PC=12: Branch=1, BranchOffset=-2 -> next PC=9. At PC=9: BranchOffset=+3 -> next PC=21. Stall=1 together with Branch -> PC stays 9.
3. Jump=1 with Branch=1, JumpTarget=60 -> PC=60. Then JumpTarget=126 -> PC holds 60, AddrFault=1 next cycle and stays set until Reset; Reset -> PC=0, AddrFault=0.
4. Halt at PC=30 -> PC holds 30, Halted=1. Jump and Branch are ignored. Resume with Stall=1 -> still HALTED. Resume alone -> PC=33, Halted=0.
5. Free-run from PC=123 -> next PC 126 exceeds 125 -> FAULT with PC=123. Assert Reset asynchronously mid-cycle -> PCAddress=0 immediately, without waiting for a clock edge.
6. PC_RAS_EN, depth 4:
   - Call to 60 from PC=0 -> PC=60, RasEmpty=0.
   - Ret -> PC=3, RasEmpty=1.
   - 5 nested Calls then 4 Rets -> PCs return in LIFO order.
   - A 5th Ret -> FAULT.
   - Without the macro: Call from PC=0 to 60 -> PC=60, then Ret -> PC=63.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the current 24-bit instruction address and selects the next PC.
// Optional return-address stack enabled by defining PC_RAS_EN.
//
// state     | meaning
// ST_RUN    | PC advances: sequential, branch, jump, call or return
// ST_HALTED | PC holds until Resume (without Stall)
// ST_FAULT  | next PC was out of range or return on empty stack; sticky until Reset
module pc_fetch_unit #(
    parameter logic [23:0] RESET_VECTOR = 24'd0,
    parameter int          IMEM_BYTES   = 128,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [11:0] BranchOffset,
    input  logic        Jump,
    input  logic [23:0] JumpTarget,
    input  logic        Call,
    input  logic        Ret,
    input  logic        Halt,
    input  logic        Resume,
    output logic [23:0] PCAddress,
    output logic [23:0] PCPlus3,
    output logic        Halted,
    output logic        AddrFault,
    output logic        RasEmpty
);

    localparam logic [23:0] MAX_PC = 24'(IMEM_BYTES - 3);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] pc_q, pc_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [23:0] seq, br, off_ext, cand, ras_top;
    logic        push, pop, ret_req, ret_fault, ras_empty, ras_on;

    assign seq     = pc_q + 24'd3;
    assign off_ext = {{12{BranchOffset[11]}}, BranchOffset};
    assign br      = seq + (off_ext << 1) + off_ext;

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [23:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_sp, ras_sp_dec;   // ras_sp is the next slot to write
    logic [CW-1:0] ras_cnt;

    assign ras_on     = 1'b1;
    assign ret_req    = Ret;
    assign ras_sp_dec = (ras_sp == '0) ? PW'(RAS_DEPTH - 1) : ras_sp - 1'b1;
    assign ras_top    = ras_mem[ras_sp_dec];
    assign ras_empty  = (ras_cnt == '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ras_sp  <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (pop) begin
            ras_sp  <= ras_sp_dec;
            ras_cnt <= ras_cnt - 1'b1;
        end else if (push) begin
            ras_mem[ras_sp] <= seq;
            ras_sp          <= (ras_sp == PW'(RAS_DEPTH - 1)) ? '0 : ras_sp + 1'b1;
            if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
        end
    end
`else
    logic unused_ras;

    assign ras_on     = 1'b0;
    assign ret_req    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = Ret ^ push ^ pop ^ (RAS_DEPTH != 0);
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        push      = 1'b0;
        pop       = 1'b0;
        cand      = seq;
        ret_fault = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (Stall) begin
                    state_d = ST_RUN;
                end else if (Halt) begin
                    state_d = ST_HALTED;
                end else begin
                    if (ret_req) begin
                        if (ras_empty) ret_fault = 1'b1;
                        else begin
                            cand = ras_top;
                            pop  = 1'b1;
                        end
                    end else if (Call || Jump) begin
                        cand = JumpTarget;
                        push = Call & ras_on;
                    end else if (Branch) begin
                        cand = br;
                    end
                    // A faulting cycle leaves the stack untouched
                    if (ret_fault || cand > MAX_PC) begin
                        state_d = ST_FAULT;
                        push    = 1'b0;
                        pop     = 1'b0;
                    end else begin
                        pc_d = cand;
                    end
                end
            end
            ST_HALTED: begin
                if (Resume && !Stall) begin
                    if (seq > MAX_PC) state_d = ST_FAULT;
                    else begin
                        pc_d    = seq;
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        halted_d = (state_d == ST_HALTED);
        fault_d  = (state_d == ST_FAULT);
    end

    assign PCAddress = pc_q;
    assign PCPlus3   = seq;
    assign Halted    = halted_q;
    assign AddrFault = fault_q;
    assign RasEmpty  = ras_empty;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized cycles
// compared against a behavioural next-PC model (stack kept as a queue).
module tb_pc_fetch_unit;

    localparam int MAXPC = 125;
    localparam int DEPTH = 4;

    logic        Clock, Reset, Stall, Branch, Jump, Call, Ret, Halt, Resume;
    logic [11:0] BranchOffset;
    logic [23:0] JumpTarget;
    logic [23:0] PCAddress, PCPlus3;
    logic        Halted, AddrFault, RasEmpty;

    int checks   = 0;
    int failures = 0;

    // model state: 0 run, 1 halted, 2 fault
    int          m_pc;
    int          m_state;
    logic [23:0] m_stack[$];

    pc_fetch_unit #(.RESET_VECTOR(24'd0), .IMEM_BYTES(128), .RAS_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Branch(Branch),
        .BranchOffset(BranchOffset), .Jump(Jump), .JumpTarget(JumpTarget),
        .Call(Call), .Ret(Ret), .Halt(Halt), .Resume(Resume),
        .PCAddress(PCAddress), .PCPlus3(PCPlus3), .Halted(Halted),
        .AddrFault(AddrFault), .RasEmpty(RasEmpty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic clear_inputs();
        Stall = 0; Branch = 0; Jump = 0; Call = 0; Ret = 0; Halt = 0; Resume = 0;
        BranchOffset = '0; JumpTarget = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    function automatic void model_reset();
        m_pc = 0;
        m_state = 0;
        m_stack.delete();
    endfunction

    function automatic void model_step();
        int  seq, cand;
        bit  fault, push, pop;
        seq = (m_pc + 3) % (1 << 24);
        fault = 0; push = 0; pop = 0; cand = seq;
        if (m_state == 0) begin
            if (Stall) begin
            end else if (Halt) begin
                m_state = 1;
            end else begin
`ifdef PC_RAS_EN
                if (Ret) begin
                    if (m_stack.size() == 0) fault = 1;
                    else begin cand = int'(m_stack[$]); pop = 1; end
                end else
`endif
                if (Call || Jump) begin
                    cand = int'(JumpTarget);
`ifdef PC_RAS_EN
                    push = Call;
`endif
                end else if (Branch) begin
                    cand = seq + 3 * int'($signed(BranchOffset));
                    cand = cand & 24'hFFFFFF;
                end
                if (fault || cand > MAXPC) m_state = 2;
                else begin
                    m_pc = cand;
                    if (pop) void'(m_stack.pop_back());
                    if (push) begin
                        m_stack.push_back(24'(seq));
                        if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
                    end
                end
            end
        end else if (m_state == 1) begin
            if (Resume && !Stall) begin
                if (seq > MAXPC) m_state = 2;
                else begin m_pc = seq; m_state = 0; end
            end
        end
    endfunction

    task automatic test_reset();
        clear_inputs();
        Reset = 1;
        #12;
        checks++; if (PCAddress !== 24'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", PCAddress); end
        checks++; if (PCPlus3 !== 24'd3) begin failures++; $display("FAIL reset_pcplus3 got=%0d exp=3", PCPlus3); end
        checks++; if (Halted !== 1'b0 || AddrFault !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", Halted, AddrFault); end
        checks++; if (RasEmpty !== 1'b1) begin failures++; $display("FAIL reset_rasempty got=%b exp=1", RasEmpty); end
        @(posedge Clock); #1;
        Reset = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (PCAddress !== 24'(3 * i) || PCPlus3 !== 24'(3 * i + 3)) begin
                failures++; $display("FAIL seq_pc got=%0d/%0d exp=%0d/%0d", PCAddress, PCPlus3, 3 * i, 3 * i + 3);
            end
        end
        checks++; if (Halted !== 1'b0 || AddrFault !== 1'b0) begin failures++; $display("FAIL seq_flags got=%b%b exp=00", Halted, AddrFault); end
    endtask

    task automatic test_branch();
        apply_reset();
        repeat (4) tick();
        Branch = 1; BranchOffset = -12'sd2;
        tick();
        checks++; if (PCAddress !== 24'd9) begin failures++; $display("FAIL branch_back got=%0d exp=9", PCAddress); end
        Stall = 1; BranchOffset = 12'sd3;
        tick();
        checks++; if (PCAddress !== 24'd9) begin failures++; $display("FAIL stall_branch got=%0d exp=9", PCAddress); end
        Stall = 0;
        tick();
        checks++; if (PCAddress !== 24'd21) begin failures++; $display("FAIL branch_fwd got=%0d exp=21", PCAddress); end
        clear_inputs();
    endtask

    task automatic test_jump_fault();
        Jump = 1; Branch = 1; BranchOffset = 12'sd3; JumpTarget = 24'd60;
        tick();
        checks++; if (PCAddress !== 24'd60) begin failures++; $display("FAIL jump_over_branch got=%0d exp=60", PCAddress); end
        Branch = 0; JumpTarget = 24'd126;
        tick();
        checks++; if (PCAddress !== 24'd60 || AddrFault !== 1'b1) begin
            failures++; $display("FAIL jump_fault got=%0d/%b exp=60/1", PCAddress, AddrFault);
        end
        JumpTarget = 24'd30;
        repeat (3) tick();
        checks++; if (PCAddress !== 24'd60 || AddrFault !== 1'b1 || Halted !== 1'b0) begin
            failures++; $display("FAIL fault_sticky got=%0d/%b/%b exp=60/1/0", PCAddress, AddrFault, Halted);
        end
        apply_reset();
        checks++; if (PCAddress !== 24'd0 || AddrFault !== 1'b0) begin
            failures++; $display("FAIL fault_reset got=%0d/%b exp=0/0", PCAddress, AddrFault);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        Jump = 1; JumpTarget = 24'd30;
        tick();
        clear_inputs();
        Halt = 1;
        tick();
        checks++; if (PCAddress !== 24'd30 || Halted !== 1'b1) begin failures++; $display("FAIL halt_enter got=%0d/%b exp=30/1", PCAddress, Halted); end
        Halt = 0; Jump = 1; Branch = 1; JumpTarget = 24'd60; BranchOffset = 12'sd2;
        tick();
        checks++; if (PCAddress !== 24'd30 || Halted !== 1'b1) begin failures++; $display("FAIL halt_ignore got=%0d/%b exp=30/1", PCAddress, Halted); end
        clear_inputs();
        Resume = 1; Stall = 1;
        tick();
        checks++; if (PCAddress !== 24'd30 || Halted !== 1'b1) begin failures++; $display("FAIL halt_stall_resume got=%0d/%b exp=30/1", PCAddress, Halted); end
        Stall = 0;
        tick();
        checks++; if (PCAddress !== 24'd33 || Halted !== 1'b0 || AddrFault !== 1'b0) begin
            failures++; $display("FAIL halt_resume got=%0d/%b/%b exp=33/0/0", PCAddress, Halted, AddrFault);
        end
        clear_inputs();
    endtask

    task automatic test_end_fault();
        apply_reset();
        Jump = 1; JumpTarget = 24'd123;
        tick();
        clear_inputs();
        Halt = 1;
        tick();
        Halt = 0; Resume = 1;
        tick();
        checks++; if (PCAddress !== 24'd123 || AddrFault !== 1'b1 || Halted !== 1'b0) begin
            failures++; $display("FAIL resume_fault got=%0d/%b/%b exp=123/1/0", PCAddress, AddrFault, Halted);
        end
        apply_reset();
        Jump = 1; JumpTarget = 24'd123;
        tick();
        clear_inputs();
        tick();
        checks++; if (PCAddress !== 24'd123 || AddrFault !== 1'b1) begin
            failures++; $display("FAIL end_fault got=%0d/%b exp=123/1", PCAddress, AddrFault);
        end
        #2;
        Reset = 1;
        #1;
        checks++; if (PCAddress !== 24'd0 || AddrFault !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%0d/%b exp=0/0", PCAddress, AddrFault);
        end
        tick();
        Reset = 0;
    endtask

    task automatic test_ras();
        int targets[5];
        int rets[4];
        targets = '{30, 45, 60, 75, 90};
        rets    = '{78, 63, 48, 33};
        apply_reset();
        Call = 1; JumpTarget = 24'd60;
        tick();
`ifdef PC_RAS_EN
        checks++; if (PCAddress !== 24'd60 || RasEmpty !== 1'b0) begin failures++; $display("FAIL ras_call got=%0d/%b exp=60/0", PCAddress, RasEmpty); end
        Call = 0; Ret = 1;
        tick();
        checks++; if (PCAddress !== 24'd3 || RasEmpty !== 1'b1) begin failures++; $display("FAIL ras_ret got=%0d/%b exp=3/1", PCAddress, RasEmpty); end
        Ret = 0; Call = 1;
        foreach (targets[i]) begin
            JumpTarget = 24'(targets[i]);
            tick();
        end
        Call = 0; Ret = 1;
        foreach (rets[i]) begin
            tick();
            checks++; if (PCAddress !== 24'(rets[i])) begin failures++; $display("FAIL ras_lifo got=%0d exp=%0d", PCAddress, rets[i]); end
        end
        checks++; if (RasEmpty !== 1'b1) begin failures++; $display("FAIL ras_drained got=%b exp=1", RasEmpty); end
        tick();
        checks++; if (PCAddress !== 24'd33 || AddrFault !== 1'b1) begin failures++; $display("FAIL ras_underflow got=%0d/%b exp=33/1", PCAddress, AddrFault); end
`else
        checks++; if (PCAddress !== 24'd60 || RasEmpty !== 1'b1) begin failures++; $display("FAIL call_as_jump got=%0d/%b exp=60/1", PCAddress, RasEmpty); end
        Call = 0; Ret = 1;
        tick();
        checks++; if (PCAddress !== 24'd63 || AddrFault !== 1'b0) begin failures++; $display("FAIL ret_ignored got=%0d/%b exp=63/0", PCAddress, AddrFault); end
`endif
        clear_inputs();
    endtask

    task automatic test_random();
        bit do_rst;
        apply_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            Stall        = ($urandom_range(9) == 0);
            Halt         = ($urandom_range(19) == 0);
            Resume       = ($urandom_range(2) == 0);
            Branch       = ($urandom_range(4) == 0);
            Jump         = ($urandom_range(9) == 0);
            Call         = ($urandom_range(7) == 0);
            Ret          = ($urandom_range(7) == 0);
            BranchOffset = 12'($urandom_range(24) - 12);
            JumpTarget   = 24'($urandom_range(130));
            do_rst = (m_state == 2 && $urandom_range(3) == 0) || ($urandom_range(99) == 0);
            if (do_rst) begin
                Reset = 1;
                model_reset();
            end else begin
                model_step();
            end
            tick();
            Reset = 0;
            checks++; if (PCAddress !== 24'(m_pc)) begin failures++; $display("FAIL rnd_pc n=%0d got=%0d exp=%0d", n, PCAddress, m_pc); end
            checks++; if (PCPlus3 !== 24'(m_pc + 3)) begin failures++; $display("FAIL rnd_pcplus3 n=%0d got=%0d exp=%0d", n, PCPlus3, m_pc + 3); end
            checks++; if (Halted !== (m_state == 1) || AddrFault !== (m_state == 2)) begin
                failures++; $display("FAIL rnd_state n=%0d got=%b%b exp_state=%0d", n, Halted, AddrFault, m_state);
            end
`ifdef PC_RAS_EN
            checks++; if (RasEmpty !== (m_stack.size() == 0)) begin failures++; $display("FAIL rnd_rasempty n=%0d got=%b exp=%b", n, RasEmpty, m_stack.size() == 0); end
`else
            checks++; if (RasEmpty !== 1'b1) begin failures++; $display("FAIL rnd_rasempty n=%0d got=%b exp=1", n, RasEmpty); end
`endif
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump_fault();
        test_halt();
        test_end_fault();
        test_ras();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
